// File: rtl/regfile_mp_sb.sv
// Multi-read, dual-write register file with optional write-to-read forwarding
// and a per-register busy scoreboard used by decode for RAW hazard detection.
module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_RD*$clog2(NREGS)-1:0]   ra,
    output logic [NUM_RD*XLEN-1:0]            rd,
    output logic [NUM_RD-1:0]                 rbusy,
    input  logic                              we0,
    input  logic [$clog2(NREGS)-1:0]          wa0,
    input  logic [XLEN-1:0]                   wd0,
    input  logic                              we1,
    input  logic [$clog2(NREGS)-1:0]          wa1,
    input  logic [XLEN-1:0]                   wd1,
    input  logic                              alloc,
    input  logic [$clog2(NREGS)-1:0]          alloc_addr,
    output logic [NREGS-1:0]                  busy_vec
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] busy;
    logic             wr0_ok;
    logic             wr1_ok;

    assign wr0_ok = we0 && !(ZERO_REG != 0 && wa0 == '0);
    assign wr1_ok = we1 && !(ZERO_REG != 0 && wa1 == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NREGS; n++) mem[n] <= '0;
            busy <= '0;
        end else begin
            // Port 1 is applied last so it wins a same-address collision.
            if (wr0_ok) mem[wa0] <= wd0;
            if (wr1_ok) mem[wa1] <= wd1;
            for (int n = 0; n < NREGS; n++) begin
                if (alloc && alloc_addr == AW'(n) && !(ZERO_REG != 0 && n == 0))
                    busy[n] <= 1'b1;
                else if ((we0 && wa0 == AW'(n)) || (we1 && wa1 == AW'(n)))
                    busy[n] <= 1'b0;
            end
        end
    end

    always_comb begin
        rd    = '0;
        rbusy = '0;
        // Outputs are forced to zero while reset is held, even if a write is forwarding.
        for (int i = 0; i < NUM_RD; i++) begin
            if (rst_n) begin
                if (ZERO_REG != 0 && ra[i*AW +: AW] == '0)
                    rd[i*XLEN +: XLEN] = '0;
                else if (BYPASS != 0 && we1 && wa1 == ra[i*AW +: AW])
                    rd[i*XLEN +: XLEN] = wd1;
                else if (BYPASS != 0 && we0 && wa0 == ra[i*AW +: AW])
                    rd[i*XLEN +: XLEN] = wd0;
                else
                    rd[i*XLEN +: XLEN] = mem[ra[i*AW +: AW]];
                rbusy[i] = busy[ra[i*AW +: AW]] &&
                           !(BYPASS != 0 && ((we0 && wa0 == ra[i*AW +: AW]) ||
                                             (we1 && wa1 == ra[i*AW +: AW])));
            end
        end
    end

    assign busy_vec = busy;

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the core's 32x32 integer register file.
- Configurable width, depth and read-port count.
- Two synchronous write ports: WB0 for ALU writeback, WB1 for load/late writeback.
- Optional write-to-read bypass, asynchronous clear, and a per-register busy scoreboard so decode can detect RAW hazards.
- Sits between decode (reads, allocation) and writeback.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, register count; power of two, at least 2. AW = $clog2(NREGS) is a localparam.
- NUM_RD, 2, number of read ports, 1..4.
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return stored value only.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ra  in  NUM_RD*AW  read addresses; port i is ra[i*AW +: AW].
- rd  out  NUM_RD*XLEN  read data; port i is rd[i*XLEN +: XLEN].
- rbusy  out  NUM_RD  scoreboard busy bit for each read address.
- we0  in  1  write enable, port 0.
- wa0  in  AW  write address, port 0.
- wd0  in  XLEN  write data, port 0.
- we1  in  1  write enable, port 1.
- wa1  in  AW  write address, port 1.
- wd1  in  XLEN  write data, port 1.
- alloc  in  1  mark a destination busy (instruction issued).
- alloc_addr  in  AW  destination being allocated.
- busy_vec  out  NREGS  full scoreboard, bit n = register n pending.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers cleared to 0;
  - all busy bits cleared;
  - rd reads 0 and rbusy reads 0 while reset is held.
- Release of rst_n takes effect at the next clk edge; no write/alloc is sampled while rst_n is low.
- Writes:
  - On posedge clk, a write port with weN=1 updates mem[waN] <= wdN.
  - Both ports to the same address in one cycle: port 1 wins.
  - ZERO_REG=1 with waN=0: write dropped.
- Reads are combinational, zero latency. rd_i is selected in this order:
  1. ZERO_REG=1 and ra_i=0 -> 0.
  2. BYPASS=1, we1 and wa1==ra_i -> wd1.
  3. BYPASS=1, we0 and wa0==ra_i -> wd0.
  4. otherwise mem[ra_i].
- BYPASS=0: a write is visible to reads from the cycle after the edge.
- Scoreboard, next-state per register n (evaluated at posedge):
  - if alloc && alloc_addr==n -> busy[n] <= 1 (alloc beats a same-cycle writeback: new producer);
  - else if (we0&&wa0==n)||(we1&&wa1==n) -> busy[n] <= 0;
  - else hold.
- A write to a non-busy register is legal and leaves busy at 0.
- ZERO_REG=1: busy[0] is constant 0 and alloc to 0 is ignored.
- rbusy_i = busy[ra_i] from the registered busy bits, with BYPASS-style override:
  - a same-cycle writeback to ra_i forces rbusy_i=0 when BYPASS=1, since the data is forwarded;
  - same-cycle alloc does not raise rbusy until the next cycle.
- busy_vec is the registered scoreboard, no bypass.
- No storage behaviour depends on initial blocks; reset is the only initialisation.
- Out-of-range addresses cannot occur because NREGS is a power of two.

Test Plan:
1. Reset values: assert rst_n=0 mid-run after writing x5=32'hDEADBEEF -> rd for ra=5 reads 0 immediately (asynchronous), and busy_vec=0.
2. Basic write/read: we0, wa0=3, wd0=32'h1234_5678, then ra0=3 the next cycle -> rd0=32'h12345678. Also write x0=32'hFFFF_FFFF -> reading 0 returns 0.
3. Bypass and port priority (BYPASS=1): same cycle we0 (wa0=7, wd0=32'hA) and we1 (wa1=7, wd1=32'hB), ra0=7 -> rd0=32'hB that cycle and 32'hB after the edge. With BYPASS=0 -> old value that cycle, 32'hB after.
4. Scoreboard lifecycle: alloc x9 -> busy_vec[9]=1 next cycle, rbusy=1 for ra=9. we1 to x9 -> rbusy=0 in the write cycle (bypass) and busy_vec[9]=0 after the edge.
5. Alloc/write collision: alloc_addr=4 and we0 wa0=4 in the same cycle -> busy_vec[4]=1 afterwards and mem[4] updated. alloc_addr=0 -> busy_vec stays 0.
6. Parametrised build: XLEN=64, NREGS=16, NUM_RD=3. Write all 16 registers with a 64-bit pattern and read them back concurrently on all three ports -> exact match, and register 0 reads 0.
